beamscaler_seq: RTL and testbench

//  Period-driven sequencer for the chain of dual-bank beam scaler DSPs.

---
 rtl/beamscaler_pkg.sv | 43 ++++
 rtl/beamscaler_seq_if.sv | 43 ++++
 rtl/beamscaler_seq.sv | 149 ++++++++++++++
 tb/tb_beamscaler_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/beamscaler_pkg.sv
// Shared constants, FSM state type and saturation-count helpers for the beam scaler sequencer.
package beamscaler_pkg;

   localparam logic [2:0]  ST_COUNT         = 3'b010;
   localparam logic [2:0]  ST_COMPUTE       = 3'b111;
   localparam logic [2:0]  ST_SHIFT         = 3'b001;
   localparam int          SCALER_LANE_BITS = 12;
   localparam logic [11:0] SCALER_SAT       = 12'hFFF;

   // B* states mirror the A-bank readout with banks swapped.
   typedef enum logic [3:0] {
      S_RST_CLR, S_INIT,
      S_IDLE_A, S_PREP_B, S_COMP_A0, S_COMP_A1, S_DSHIFT_A, S_PSHIFT_A, S_PREP_A,
      S_IDLE_B, S_BPREP_A, S_COMP_B0, S_COMP_B1, S_DSHIFT_B, S_PSHIFT_B, S_BPREP_B
   } fsm_state_e;

   typedef struct packed {
      logic [2:0] state;
      logic [1:0] state_ce;
      logic [1:0] dsp_ce;
      logic       rstp;
   } dsp_ctrl_t;

   function automatic logic [2:0] sat_lanes(input logic [47:0] word);
      logic [2:0] n;
      n = 3'd0;
      for (int k = 0; k < 4; k++) begin
         if (word[k*SCALER_LANE_BITS +: SCALER_LANE_BITS] == SCALER_SAT) begin
            n = n + 3'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [2:0] inc);
      logic [8:0] sum;
      sum = {1'b0, acc} + {6'd0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/beamscaler_seq_if.sv
// Sequencer bus: period tick and chain tail in, DSP controls and scaler RAM write port out.
// Carries sat_cnt_o only when BEAMSCALER_SATCOUNT_EN is defined.
interface beamscaler_seq_if #(
   parameter int ADDR_BITS = 5
);
   logic                 wb_clk_ce_i;
   logic [95:0]          tail_i;
   logic [2:0]           state_o;
   logic [1:0]           state_ce_o;
   logic [1:0]           dsp_ce_o;
   logic                 rstp_o;
   logic                 wr_en_o;
   logic [ADDR_BITS-1:0] wr_addr_o;
   logic [47:0]          wr_data_o;
   logic                 done_o;
   logic                 done_buf_o;
   logic                 overrun_o;
`ifdef BEAMSCALER_SATCOUNT_EN
   logic [7:0]           sat_cnt_o;

   modport master (
      input  wb_clk_ce_i, tail_i,
      output state_o, state_ce_o, dsp_ce_o, rstp_o, wr_en_o, wr_addr_o, wr_data_o,
             done_o, done_buf_o, overrun_o, sat_cnt_o
   );
   modport slave (
      output wb_clk_ce_i, tail_i,
      input  state_o, state_ce_o, dsp_ce_o, rstp_o, wr_en_o, wr_addr_o, wr_data_o,
             done_o, done_buf_o, overrun_o, sat_cnt_o
   );
`else
   modport master (
      input  wb_clk_ce_i, tail_i,
      output state_o, state_ce_o, dsp_ce_o, rstp_o, wr_en_o, wr_addr_o, wr_data_o,
             done_o, done_buf_o, overrun_o
   );
   modport slave (
      output wb_clk_ce_i, tail_i,
      input  state_o, state_ce_o, dsp_ce_o, rstp_o, wr_en_o, wr_addr_o, wr_data_o,
             done_o, done_buf_o, overrun_o
   );
`endif
endinterface

// File: rtl/beamscaler_seq.sv
// Period-driven sequencer for the dual-bank beam scaler DSP chain with ping-pong capture.
// Optional BEAMSCALER_SATCOUNT_EN adds a per-period saturated-lane counter (sat_cnt_o).
module beamscaler_seq
   import beamscaler_pkg::*;
#(
   parameter int NUM_SCALERS = 12,
   parameter int ADDR_BITS   = $clog2(NUM_SCALERS) + 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   beamscaler_seq_if.master      bus
);

   localparam int IDX_BITS = ADDR_BITS - 1;
   localparam dsp_ctrl_t CTRL_RST = '{state: ST_COUNT, state_ce: 2'b00, dsp_ce: 2'b00, rstp: 1'b1};

   fsm_state_e           state_r, state_next_s;
   dsp_ctrl_t            ctrl_s, ctrl_r;
   logic [IDX_BITS-1:0]  idx_r;
   logic                 buf_r;
   logic                 wr_en_r, done_r, done_buf_r, overrun_r;
   logic [ADDR_BITS-1:0] wr_addr_r;
   logic [47:0]          wr_data_r;
   logic                 idle_s, capture_s, exit_s;
   logic [47:0]          tail_word_s;

   assign idle_s      = (state_r == S_IDLE_A) || (state_r == S_IDLE_B);
   assign capture_s   = (state_r == S_DSHIFT_A) || (state_r == S_DSHIFT_B);
   assign exit_s      = (state_r == S_PREP_A) || (state_r == S_BPREP_B);
   assign tail_word_s = (state_r == S_DSHIFT_B) ? bus.tail_i[95:48] : bus.tail_i[47:0];

   // Next-state logic; ticks outside the idle states are ignored here.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_RST_CLR:  state_next_s = S_INIT;
         S_INIT:     state_next_s = S_IDLE_A;
         S_IDLE_A:   state_next_s = bus.wb_clk_ce_i ? S_PREP_B : S_IDLE_A;
         S_PREP_B:   state_next_s = S_COMP_A0;
         S_COMP_A0:  state_next_s = S_COMP_A1;
         S_COMP_A1:  state_next_s = S_DSHIFT_A;
         S_DSHIFT_A: state_next_s = (idx_r == '0) ? S_PREP_A : S_PSHIFT_A;
         S_PSHIFT_A: state_next_s = S_DSHIFT_A;
         S_PREP_A:   state_next_s = S_IDLE_B;
         S_IDLE_B:   state_next_s = bus.wb_clk_ce_i ? S_BPREP_A : S_IDLE_B;
         S_BPREP_A:  state_next_s = S_COMP_B0;
         S_COMP_B0:  state_next_s = S_COMP_B1;
         S_COMP_B1:  state_next_s = S_DSHIFT_B;
         S_DSHIFT_B: state_next_s = (idx_r == '0) ? S_BPREP_B : S_PSHIFT_B;
         S_PSHIFT_B: state_next_s = S_DSHIFT_B;
         S_BPREP_B:  state_next_s = S_IDLE_A;
         default:    state_next_s = S_RST_CLR;
      endcase
   end

   // DSP control table, decoded from the next state so the registered outputs track state_r.
   always_comb begin
      ctrl_s = CTRL_RST;
      case (state_next_s)
         S_RST_CLR:  ctrl_s = CTRL_RST;
         S_INIT:     ctrl_s = '{ST_COUNT,   2'b11, 2'b00, 1'b0};
         S_IDLE_A:   ctrl_s = '{ST_COUNT,   2'b00, 2'b01, 1'b0};
         S_PREP_B:   ctrl_s = '{ST_COUNT,   2'b10, 2'b01, 1'b0};
         S_COMP_A0:  ctrl_s = '{ST_COMPUTE, 2'b01, 2'b10, 1'b0};
         S_COMP_A1:  ctrl_s = '{ST_COMPUTE, 2'b00, 2'b11, 1'b0};
         S_DSHIFT_A: ctrl_s = '{ST_SHIFT,   2'b01, 2'b10, 1'b0};
         S_PSHIFT_A: ctrl_s = '{ST_SHIFT,   2'b00, 2'b11, 1'b0};
         S_PREP_A:   ctrl_s = '{ST_COUNT,   2'b01, 2'b10, 1'b0};
         S_IDLE_B:   ctrl_s = '{ST_COUNT,   2'b00, 2'b10, 1'b0};
         S_BPREP_A:  ctrl_s = '{ST_COUNT,   2'b01, 2'b10, 1'b0};
         S_COMP_B0:  ctrl_s = '{ST_COMPUTE, 2'b10, 2'b01, 1'b0};
         S_COMP_B1:  ctrl_s = '{ST_COMPUTE, 2'b00, 2'b11, 1'b0};
         S_DSHIFT_B: ctrl_s = '{ST_SHIFT,   2'b10, 2'b01, 1'b0};
         S_PSHIFT_B: ctrl_s = '{ST_SHIFT,   2'b00, 2'b11, 1'b0};
         S_BPREP_B:  ctrl_s = '{ST_COUNT,   2'b10, 2'b01, 1'b0};
         default:    ctrl_s = CTRL_RST;
      endcase
   end

   // State register, capture/write port, buffer toggle and completion flags.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r    <= S_RST_CLR;
         ctrl_r     <= CTRL_RST;
         idx_r      <= '0;
         buf_r      <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= 48'd0;
         done_r     <= 1'b0;
         done_buf_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ctrl_r  <= ctrl_s;
         wr_en_r <= capture_s;
         done_r  <= exit_s;
         if (capture_s) begin
            wr_addr_r <= {buf_r, idx_r};
            wr_data_r <= tail_word_s;
            idx_r     <= idx_r - {{(IDX_BITS-1){1'b0}}, 1'b1};
         end else if (idle_s) begin
            idx_r <= IDX_BITS'(NUM_SCALERS - 1);
         end
         if (exit_s) begin
            done_buf_r <= buf_r;
            buf_r      <= ~buf_r;
         end
         if (bus.wb_clk_ce_i && !idle_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

`ifdef BEAMSCALER_SATCOUNT_EN
   logic [7:0] sat_acc_r, sat_cnt_r;

   // Saturated lanes accumulate over a readout and publish together with done_o.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sat_acc_r <= 8'd0;
         sat_cnt_r <= 8'd0;
      end else begin
         if (idle_s) begin
            sat_acc_r <= 8'd0;
         end else if (capture_s) begin
            sat_acc_r <= sat_add8(sat_acc_r, sat_lanes(tail_word_s));
         end
         if (exit_s) begin
            sat_cnt_r <= sat_acc_r;
         end
      end
   end

   assign bus.sat_cnt_o = sat_cnt_r;
`endif

   assign bus.state_o    = ctrl_r.state;
   assign bus.state_ce_o = ctrl_r.state_ce;
   assign bus.dsp_ce_o   = ctrl_r.dsp_ce;
   assign bus.rstp_o     = ctrl_r.rstp;
   assign bus.wr_en_o    = wr_en_r;
   assign bus.wr_addr_o  = wr_addr_r;
   assign bus.wr_data_o  = wr_data_r;
   assign bus.done_o     = done_r;
   assign bus.done_buf_o = done_buf_r;
   assign bus.overrun_o  = overrun_r;

endmodule

// File: tb/tb_beamscaler_seq.sv
// Scoreboard bench for beamscaler_seq: expected writes/done pushed by stimulus, popped by a monitor.
module tb_beamscaler_seq;

   localparam int N  = 12;
   localparam int AB = 5;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic exp_buf = 1'b0;
   logic [52:0] wq[$];
   logic        dq[$];

   always #5 wb_clk_i = ~wb_clk_i;

   beamscaler_seq_if #(.ADDR_BITS(AB)) bus();
   beamscaler_seq #(.NUM_SCALERS(N), .ADDR_BITS(AB)) dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_i(wb_rst_i),
      .bus(bus)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] word(input int idx, input int half);
      logic [47:0] w;
      for (int k = 0; k < 4; k++) w[k*12 +: 12] = 12'(half * 1024 + k * 64 + idx);
      if (half == 0 && idx == 2) w[11:0] = 12'hFFF;
      if (half == 0 && idx == 5) w[23:0] = 24'hFFFFFF;
      return w;
   endfunction

   // Monitor: every write and every done pulse must match the head of its queue.
   always @(negedge wb_clk_i) begin
      logic [52:0] e;
      if (bus.wr_en_o === 1'b1) begin
         if (wq.size() == 0) begin
            check("unexpected_write", 64'(bus.wr_addr_o), 64'h0BAD);
         end else begin
            e = wq.pop_front();
            check("wr_addr", 64'(bus.wr_addr_o), 64'(e[52:48]));
            check("wr_data", 64'(bus.wr_data_o), 64'(e[47:0]));
         end
      end
      if (bus.done_o === 1'b1) begin
         if (dq.size() == 0) begin
            check("unexpected_done", 64'(bus.done_o), 64'd0);
         end else begin
            check("done_buf", 64'(bus.done_buf_o), 64'(dq.pop_front()));
         end
      end
   end

   function automatic logic [11:0] ctrl_vec();
      return {bus.state_o, bus.state_ce_o, bus.dsp_ce_o, bus.rstp_o,
              bus.wr_en_o, bus.done_o, bus.done_buf_o, bus.overrun_o};
   endfunction

   // One readout from tick; rst_at >= 0 pulses reset at that cycle instead of completing.
   task automatic run_readout(input int bank, input int inject_at, input int rst_at);
      int idx;
      for (int j = 0; j < N; j++) begin
         idx = N - 1 - j;
         if (rst_at < 0 || 4 + 2 * j <= rst_at)
            wq.push_back({exp_buf, 4'(idx), word(idx, bank)});
      end
      if (rst_at < 0) dq.push_back(exp_buf);
      @(posedge wb_clk_i); #1;
      bus.wb_clk_ce_i = 1'b1;
      @(posedge wb_clk_i); #1;
      for (int c = 0; c < 30; c++) begin
         idx = (c < 3) ? N - 1 : N - 1 - (c - 3) / 2;
         if (idx < 0) idx = 0;
         bus.tail_i      = {word(idx, 1), word(idx, 0)};
         bus.wb_clk_ce_i = (c == inject_at);
         if (c == rst_at) wb_rst_i = 1'b1;
         else if (rst_at >= 0 && c == rst_at + 1) wb_rst_i = 1'b0;
         if (rst_at < 0) begin
            if (c == 1)
               check("compute_ctrl", 64'({bus.state_o, bus.state_ce_o, bus.dsp_ce_o}),
                     bank == 0 ? 64'b111_01_10 : 64'b111_10_01);
            if (c == 3)
               check("shift_ctrl", 64'({bus.state_o, bus.state_ce_o, bus.dsp_ce_o}),
                     bank == 0 ? 64'b001_01_10 : 64'b001_10_01);
            if (c == 26) check("done_early", 64'(bus.done_o), 64'd0);
            if (c == 27) begin
               check("done_at_len", 64'(bus.done_o), 64'd1);
`ifdef BEAMSCALER_SATCOUNT_EN
               check("sat_cnt", 64'(bus.sat_cnt_o), bank == 0 ? 64'd3 : 64'd0);
`endif
            end
         end else begin
            if (c == rst_at + 1) begin
               check("rst_ctrl", 64'(ctrl_vec()), 64'b010_00_00_1_0_0_0_0);
               check("rst_addr", 64'(bus.wr_addr_o), 64'd0);
               check("rst_data", 64'(bus.wr_data_o), 64'd0);
            end
            if (c == rst_at + 2)
               check("rst_init", 64'({bus.state_ce_o, bus.rstp_o}), 64'b11_0);
            if (c == rst_at + 3)
               check("restart_idle_a", 64'({bus.state_ce_o, bus.dsp_ce_o}), 64'b00_01);
         end
         @(posedge wb_clk_i); #1;
      end
      if (rst_at < 0) exp_buf = ~exp_buf;
   endtask

   initial begin
      bus.wb_clk_ce_i = 1'b0;
      bus.tail_i      = 96'd0;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      check("reset_ctrl", 64'(ctrl_vec()), 64'b010_00_00_1_0_0_0_0);
      check("reset_addr", 64'(bus.wr_addr_o), 64'd0);
      check("reset_data", 64'(bus.wr_data_o), 64'd0);
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      check("rst_clr_rstp", 64'(bus.rstp_o), 64'd1);
      @(posedge wb_clk_i); #1;
      check("init_ctrl", 64'({bus.state_ce_o, bus.dsp_ce_o, bus.rstp_o}), 64'b11_00_0);
      for (int i = 0; i < 6; i++) begin
         @(posedge wb_clk_i); #1;
         check("idle_a_ctrl", 64'({bus.state_ce_o, bus.dsp_ce_o, bus.rstp_o}), 64'b00_01_0);
      end
      check("overrun_idle", 64'(bus.overrun_o), 64'd0);
      run_readout(0, -1, -1);
      check("idle_b_dsp_ce", 64'(bus.dsp_ce_o), 64'b10);
      run_readout(1, -1, -1);
      check("overrun_clean", 64'(bus.overrun_o), 64'd0);
      run_readout(0, 5, -1);
      check("overrun_set", 64'(bus.overrun_o), 64'd1);
      run_readout(1, -1, -1);
      run_readout(0, -1, 4);
      check("overrun_cleared", 64'(bus.overrun_o), 64'd0);
      check("writes_drained", 64'(wq.size()), 64'd0);
      check("dones_drained", 64'(dq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
